// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi -- multi-item vending controller.
//
// Takes coins from the acceptor front end and keeps a running credit, a
// per-item price table and per-item stock counters. A buy releases the
// item (one-cycle vend pulse) and then pays any remaining credit back
// coin-by-coin, largest denomination first, over a valid/ready handshake
// to the coin hopper. Cancel refunds the whole credit the same way.
//
// Ports:
//   clk, rst         clock (rising edge) and synchronous active-low reset
//   coin             00 none, 01/10/11 = COIN1/COIN2/COIN3, sampled each cycle
//   sel, buy         item index and purchase request
//   cancel           refund request
//   restock          reload every stock counter to STOCK_INIT (IDLE only)
//   change_ready     hopper has taken the current change coin
//   vend, vend_item  item-release pulse and the index it releases
//   deny             buy refused (not enough credit, sold out or bad index)
//   coin_reject      inserted coin returned without being credited
//   change_valid     a change coin is pending; change_coin is its code
//   credit           current credit
//   busy             vending or paying change
//   empty            bit i set when item i is sold out
//
// Optional build macro VEND_AUDIT_EN adds sales_total and vend_count,
// both 16-bit saturating counters cleared by reset.

module vend_ctrl_multi #(
  parameter int CREDIT_W   = 8,
  parameter int NUM_ITEMS  = 4,
  parameter int COIN1_VAL  = 5,
  parameter int COIN2_VAL  = 10,
  parameter int COIN3_VAL  = 25,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd50, 8'd35, 8'd20, 8'd15},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2,
  localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coin,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic                 restock,
  input  logic                 change_ready,
  output logic                 vend,
  output logic [SEL_W-1:0]     vend_item,
  output logic                 deny,
  output logic                 coin_reject,
  output logic                 change_valid,
  output logic [1:0]           change_coin,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] empty
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]          sales_total,
  output logic [15:0]          vend_count
`endif
);

  // Tables are padded to the full sel range; padded slots read as price 0 /
  // stock 0, so an out-of-range sel is always an illegal buy.
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = (CREDIT_W+1)'(COIN1_VAL);
      2'b10:   coin_value = (CREDIT_W+1)'(COIN2_VAL);
      2'b11:   coin_value = (CREDIT_W+1)'(COIN3_VAL);
      default: coin_value = '0;
    endcase
  endfunction

  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(COIN3_VAL))      greedy_coin = 2'b11;
    else if (c >= CREDIT_W'(COIN2_VAL)) greedy_coin = 2'b10;
    else                                greedy_coin = 2'b01;
  endfunction

  state_t               state, state_nxt;
  logic [CREDIT_W-1:0]  credit_nxt;
  logic                 vend_nxt, deny_nxt, reject_nxt;
  logic [SEL_W-1:0]     item_nxt;
  logic                 buy_take;
  logic                 restock_now;
  logic                 buy_legal;
  logic [CREDIT_W-1:0]  price_tbl  [NSLOT];
  logic [STOCK_W-1:0]   stock_view [NSLOT];
  logic [CREDIT_W-1:0]  price_sel;
  logic [CREDIT_W:0]    coin_sum;
  logic [CREDIT_W:0]    change_val;

  assign restock_now  = restock && (state == S_IDLE);
  assign price_sel    = price_tbl[sel];
  assign buy_legal    = buy && (credit >= price_sel) && (stock_view[sel] != '0);
  assign coin_sum     = {1'b0, credit} + coin_value(coin);
  assign change_valid = (state == S_CHANGE);
  assign change_coin  = change_valid ? greedy_coin(credit) : 2'b00;
  assign change_val   = coin_value(change_coin);
  assign busy         = (state == S_VEND) || (state == S_CHANGE);

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_ITEMS) begin : g_item
      logic [STOCK_W-1:0] cnt;
      logic               take;
      assign take = buy_take && (sel == SEL_W'(g));
      // A buy in the restock cycle still consumes one unit of the fresh stock.
      always_ff @(posedge clk) begin
        if (!rst)             cnt <= STOCK_W'(STOCK_INIT);
        else if (restock_now) cnt <= take ? STOCK_W'(STOCK_INIT - 1) : STOCK_W'(STOCK_INIT);
        else if (take)        cnt <= cnt - STOCK_W'(1);
      end
      assign stock_view[g] = cnt;
      assign price_tbl[g]  = PRICES[g*CREDIT_W +: CREDIT_W];
      assign empty[g]      = (cnt == '0);
    end else begin : g_pad
      assign stock_view[g] = '0;
      assign price_tbl[g]  = '0;
    end
  end

  // Next-state: cancel beats buy beats coin while accepting money.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    vend_nxt   = 1'b0;
    item_nxt   = vend_item;
    deny_nxt   = 1'b0;
    reject_nxt = 1'b0;
    buy_take   = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (cancel) begin
          if (credit != '0) state_nxt = S_CHANGE;
          reject_nxt = (coin != 2'b00);
        end else if (buy_legal) begin
          buy_take   = 1'b1;
          state_nxt  = S_VEND;
          credit_nxt = credit - price_sel;
          vend_nxt   = 1'b1;
          item_nxt   = sel;
          reject_nxt = (coin != 2'b00);
        end else begin
          deny_nxt = buy;
          if (coin != 2'b00) begin
            if (coin_sum <= CREDIT_MAX) begin
              credit_nxt = coin_sum[CREDIT_W-1:0];
              state_nxt  = S_COLLECT;
            end else begin
              reject_nxt = 1'b1;
            end
          end
        end
      end
      S_VEND: begin
        reject_nxt = (coin != 2'b00);
        state_nxt  = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        reject_nxt = (coin != 2'b00);
        if (change_ready) begin
          credit_nxt = credit - change_val[CREDIT_W-1:0];
          if (credit_nxt == '0) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      deny        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend        <= vend_nxt;
      vend_item   <= item_nxt;
      deny        <= deny_nxt;
      coin_reject <= reject_nxt;
    end
  end

`ifdef VEND_AUDIT_EN
  // Booked at the buy edge, so the totals move together with the vend pulse.
  logic [16:0] sales_sum;
  assign sales_sum = {1'b0, sales_total} + 17'(price_sel);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sales_total <= '0;
      vend_count  <= '0;
    end else if (buy_take) begin
      sales_total <= sales_sum[16] ? 16'hFFFF : sales_sum[15:0];
      if (vend_count != 16'hFFFF) vend_count <= vend_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Testbench for vend_ctrl_multi: directed scenarios followed by random
// traffic, checked by a scoreboard fed from a transaction-level model.

module tb_vend_ctrl_multi;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       buy = 1'b0, cancel = 1'b0, restock = 1'b0, change_ready = 1'b0;
  logic       vend;
  logic [1:0] vend_item;
  logic       deny, coin_reject, change_valid;
  logic [1:0] change_coin;
  logic [7:0] credit;
  logic       busy;
  logic [3:0] empty;
`ifdef VEND_AUDIT_EN
  logic [15:0] sales_total, vend_count;
`endif

  always #5 clk = ~clk;

  vend_ctrl_multi dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .buy(buy), .cancel(cancel),
    .restock(restock), .change_ready(change_ready), .vend(vend),
    .vend_item(vend_item), .deny(deny), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_coin(change_coin), .credit(credit),
    .busy(busy), .empty(empty)
`ifdef VEND_AUDIT_EN
    , .sales_total(sales_total), .vend_count(vend_count)
`endif
  );

  typedef enum {P_ACC, P_VEND, P_CHG} phase_t;
  typedef struct {
    int tag; int credit; int cv; int cc; int busy; int empty; int sales; int vcnt;
  } exp_t;

  int     price [NI] = '{15, 20, 35, 50};
  int     m_credit = 0;
  int     m_stock [NI];
  int     m_sales = 0, m_vcnt = 0;
  phase_t m_phase = P_ACC;
  int     pay_q [$];

  exp_t   cyc_q [$];
  int     vend_q [$], item_q [$], deny_q [$], rej_q [$];

  int     n_cmp = 0, n_err = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int coin_val(int c);
    case (c)
      1: return 5;
      2: return 10;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  // The whole refund is planned up front as a list of coins, largest first.
  function automatic void plan_change(int c);
    pay_q.delete();
    while (c > 0) begin
      if (c >= 25)      begin pay_q.push_back(3); c -= 25; end
      else if (c >= 10) begin pay_q.push_back(2); c -= 10; end
      else              begin pay_q.push_back(1); c -= 5;  end
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs and record what the model says must follow.
  task automatic step(bit r, int c, int s, bit b, bit cn, bit rs, bit rdy);
    int   t;
    int   emask;
    exp_t e;
    @(negedge clk);
    rst = r; coin = 2'(c); sel = 2'(s); buy = b; cancel = cn;
    restock = rs; change_ready = rdy;
    t = cyc + 1;
    if (!r) begin
      m_credit = 0; m_phase = P_ACC; pay_q.delete();
      m_sales = 0; m_vcnt = 0;
      foreach (m_stock[i]) m_stock[i] = 2;
    end else begin
      case (m_phase)
        P_ACC: begin
          if (rs && m_credit == 0) foreach (m_stock[i]) m_stock[i] = 2;
          if (cn) begin
            if (m_credit > 0) begin m_phase = P_CHG; plan_change(m_credit); end
            if (c != 0) rej_q.push_back(t);
          end else if (b && s < NI && m_credit >= price[s] && m_stock[s] > 0) begin
            m_credit -= price[s];
            m_stock[s]--;
            m_phase = P_VEND;
            vend_q.push_back(t); item_q.push_back(s);
            m_sales = (m_sales + price[s] > 65535) ? 65535 : m_sales + price[s];
            m_vcnt  = (m_vcnt == 65535) ? 65535 : m_vcnt + 1;
            if (c != 0) rej_q.push_back(t);
          end else begin
            if (b) deny_q.push_back(t);
            if (c != 0) begin
              if (m_credit + coin_val(c) <= 255) m_credit += coin_val(c);
              else rej_q.push_back(t);
            end
          end
        end
        P_VEND: begin
          if (c != 0) rej_q.push_back(t);
          if (m_credit > 0) begin m_phase = P_CHG; plan_change(m_credit); end
          else m_phase = P_ACC;
        end
        default: begin
          if (c != 0) rej_q.push_back(t);
          if (rdy) begin
            m_credit -= coin_val(pay_q.pop_front());
            if (pay_q.size() == 0) m_phase = P_ACC;
          end
        end
      endcase
    end
    emask = 0;
    for (int i = 0; i < NI; i++) if (m_stock[i] == 0) emask |= (1 << i);
    e.tag    = t;
    e.credit = m_credit;
    e.cv     = (m_phase == P_CHG) ? 1 : 0;
    e.cc     = (m_phase == P_CHG) ? pay_q[0] : 0;
    e.busy   = (m_phase != P_ACC) ? 1 : 0;
    e.empty  = emask;
    e.sales  = m_sales;
    e.vcnt   = m_vcnt;
    cyc_q.push_back(e);
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: compares DUT outputs against whatever the model queued for this cycle.
  initial begin
    exp_t e;
    bit   ev;
    int   it;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0 && cyc_q[0].tag == cyc) begin
        e = cyc_q.pop_front();
        chk("credit", int'(credit), e.credit);
        chk("change_valid", int'(change_valid), e.cv);
        chk("change_coin", int'(change_coin), e.cc);
        chk("busy", int'(busy), e.busy);
        chk("empty", int'(empty), e.empty);
`ifdef VEND_AUDIT_EN
        chk("sales_total", int'(sales_total), e.sales);
        chk("vend_count", int'(vend_count), e.vcnt);
`endif
        ev = (vend_q.size() > 0 && vend_q[0] == cyc);
        chk("vend", int'(vend), int'(ev));
        if (ev) begin
          void'(vend_q.pop_front());
          it = item_q.pop_front();
          if (vend) chk("vend_item", int'(vend_item), it);
        end
        ev = (deny_q.size() > 0 && deny_q[0] == cyc);
        chk("deny", int'(deny), int'(ev));
        if (ev) void'(deny_q.pop_front());
        ev = (rej_q.size() > 0 && rej_q[0] == cyc);
        chk("coin_reject", int'(coin_reject), int'(ev));
        if (ev) void'(rej_q.pop_front());
      end
    end
  end

  initial begin
    foreach (m_stock[i]) m_stock[i] = 2;

    // reset
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // exact payment for item 0, no change
    step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // overpay by one COIN2
    step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // change held while the hopper stalls
    step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);
`ifdef VEND_AUDIT_EN
    chk("sales_total_after_three", int'(sales_total), 80);
    chk("vend_count_after_three", int'(vend_count), 3);
`endif

    // deny on short credit, then cancel; reset during a refund
    step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // sell out item 0, deny, refund, restock
    repeat (2) begin
      step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);
    end
    chk("empty0_sold_out", int'(empty[0]), 1);
    step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("empty0_restocked", int'(empty[0]), 0);

    // credit ceiling, coin during refund
    repeat (10) step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("credit_at_max", int'(credit), 255);
    step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reject_at_max", int'(coin_reject), 1);
    step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(15, 1'b1);

    // random traffic
    repeat (3000) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 1) == 1));
    end
    idle(1, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    chk("cycle_q_drained", cyc_q.size(), 0);
    chk("vend_q_drained", vend_q.size(), 0);
    chk("deny_q_drained", deny_q.size(), 0);
    chk("reject_q_drained", rej_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
